// File: rtl/bus_controller.sv
// bus_controller: single-master bridge from the picorv32 native memory
// interface to the SoC slaves (ROM, RAM, IO registers).
// Each request is decoded against three address windows. A legal hit drives
// a one-hot select to that slave and returns its ready/rdata. An illegal
// access is answered with an error response carrying ERR_RDATA. The first
// faulting address since reset is recorded in err_addr_out.
// Optional build macro: BUS_TIMEOUT_EN. When it is defined, an ACCESS that
// waits TIMEOUT_CYCLES cycles without the selected ready is aborted into an
// error response.
module bus_controller #(
    parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
    parameter logic [31:0] RAM_BASE       = 32'h0000_1000,
    parameter logic [31:0] MEM_SIZE       = 32'h0000_1000,
    parameter logic [31:0] IO_BASE        = 32'h1000_0000,
    parameter logic [31:0] IO_SIZE        = 32'h0000_0010,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        cpu_valid,
    input  logic        cpu_instr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic [2:0]  sel_out,
    output logic        write_out,
    output logic [29:0] addr_out,
    output logic [31:0] wdata_out,
    output logic [3:0]  wstrb_out,
    input  logic [2:0]  slv_ready_in,
    input  logic [95:0] slv_rdata_in,
    output logic        bus_error_out,
    output logic [31:0] err_addr_out
);

    localparam int NUM_SLV = 3;

    // Slave index order matches sel_out: 0=ROM, 1=RAM, 2=IO
    localparam logic [31:0] WIN_BASE [NUM_SLV] = '{ROM_BASE, RAM_BASE, IO_BASE};
    localparam logic [31:0] WIN_SIZE [NUM_SLV] = '{MEM_SIZE, MEM_SIZE, IO_SIZE};

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERROR
    } state_t;

    state_t      state_q, state_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [2:0]  sel_q, sel_d;
    logic        write_q, write_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bus_error_q, bus_error_d;
    logic [31:0] err_addr_q, err_addr_d;

    // Request decode
    logic [2:0]  win_hit;
    logic [2:0]  req_legal;
    logic [2:0]  req_sel;
    logic        req_aligned;
    logic [29:0] win_off [NUM_SLV];
    logic [29:0] req_word;

    // Return path from the selected slave
    logic [2:0]  slv_rdy_masked;
    logic [31:0] slv_rdata_masked [NUM_SLV];
    logic [31:0] sel_rdata;
    logic        sel_ready;

    // Unsigned window test; the 33-bit limit keeps a window touching the top
    // of the address space from wrapping to zero.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [32:0] limit;
        limit = {1'b0, base} + {1'b0, size};
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
            assign win_hit[gi]          = in_window(cpu_addr, WIN_BASE[gi], WIN_SIZE[gi]);
            assign win_off[gi]          = cpu_addr[31:2] - WIN_BASE[gi][31:2];
            // Only the selected slave may complete the access
            assign slv_rdy_masked[gi]   = sel_q[gi] & slv_ready_in[gi];
            assign slv_rdata_masked[gi] = sel_q[gi] ? slv_rdata_in[32*gi +: 32] : 32'h0;
        end
    endgenerate

    // ROM is read-only (fetch or data); RAM and IO refuse instruction fetches
    assign req_legal[0] = win_hit[0] && (cpu_wstrb == 4'b0000);
    assign req_legal[1] = win_hit[1] && !cpu_instr;
    assign req_legal[2] = win_hit[2] && !cpu_instr;
    assign req_aligned  = (cpu_addr[1:0] == 2'b00);
    assign req_sel      = req_aligned ? req_legal : 3'b000;
    assign sel_ready    = |slv_rdy_masked;

    // Window-relative word address of the request and OR-reduced slave read data
    always_comb begin
        req_word  = cpu_addr[31:2];
        sel_rdata = 32'h0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (req_sel[i]) begin
                req_word = win_off[i];
            end
            sel_rdata = sel_rdata | slv_rdata_masked[i];
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic             tmo_expire;

    // The current ACCESS cycle is the last one allowed without ready
    assign tmo_expire = ((32'(tmo_q) + 32'd1) >= TIMEOUT_CYCLES);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Next-state, response and capture logic of the transaction FSM
    always_comb begin
        state_d     = state_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        sel_d       = sel_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bus_error_d = bus_error_q;
        err_addr_d  = err_addr_q;
`ifdef BUS_TIMEOUT_EN
        tmo_d       = tmo_q;
        req_addr_d  = req_addr_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_valid) begin
                    addr_d  = req_word;
                    wdata_d = cpu_wdata;
                    wstrb_d = cpu_wstrb;
                    write_d = |cpu_wstrb;
                    if (req_sel != 3'b000) begin
                        sel_d   = req_sel;
                        state_d = ACCESS;
`ifdef BUS_TIMEOUT_EN
                        tmo_d      = '0;
                        req_addr_d = cpu_addr;
`endif
                    end else begin
                        // Decode fault: answer without touching any slave
                        state_d     = ERROR;
                        cpu_ready_d = 1'b1;
                        cpu_rdata_d = ERR_RDATA;
                        bus_error_d = 1'b1;
                        if (!bus_error_q) begin
                            err_addr_d = cpu_addr;
                        end
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    cpu_rdata_d = sel_rdata;
                    cpu_ready_d = 1'b1;
                    sel_d       = 3'b000;
                    state_d     = RESP;
                end
`ifdef BUS_TIMEOUT_EN
                else if (tmo_expire) begin
                    // Slave never answered: abort into the error response
                    sel_d       = 3'b000;
                    state_d     = ERROR;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = ERR_RDATA;
                    bus_error_d = 1'b1;
                    if (!bus_error_q) begin
                        err_addr_d = req_addr_q;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            ERROR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= 32'h0;
            sel_q       <= 3'b000;
            write_q     <= 1'b0;
            addr_q      <= 30'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            bus_error_q <= 1'b0;
            err_addr_q  <= 32'h0;
`ifdef BUS_TIMEOUT_EN
            tmo_q       <= '0;
            req_addr_q  <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            sel_q       <= sel_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bus_error_q <= bus_error_d;
            err_addr_q  <= err_addr_d;
`ifdef BUS_TIMEOUT_EN
            tmo_q       <= tmo_d;
            req_addr_q  <= req_addr_d;
`endif
        end
    end

    assign cpu_ready     = cpu_ready_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign sel_out       = sel_q;
    assign write_out     = write_q;
    assign addr_out      = addr_q;
    assign wdata_out     = wdata_q;
    assign wstrb_out     = wstrb_q;
    assign bus_error_out = bus_error_q;
    assign err_addr_out  = err_addr_q;

endmodule

// File: doc/bus_controller.md
Name: bus_controller

Overview:
Single-master bus controller between the picorv32 native memory interface and the SoC slaves: ROM, RAM and the IO register block.
- Replaces the ad-hoc address decode and shared ready/rdata wiring in the top level.
- Decodes each request, drives a one-hot select to exactly one slave and muxes the selected slave's ready/rdata back.
- Turns illegal accesses into an error response instead of a hung CPU, and records the first faulting address.

Parameters:
ROM_BASE, 32'h0000_0000, ROM window base (instruction fetch and data read only)
RAM_BASE, 32'h0000_1000, RAM window base (data read/write only)
MEM_SIZE, 32'h0000_1000, byte size of the ROM and RAM windows
IO_BASE, 32'h1000_0000, IO window base (data read/write only)
IO_SIZE, 32'h0000_0010, IO window byte size
ERR_RDATA, 32'hDEAD_BEEF, read data returned on an error response
TIMEOUT_CYCLES, 255, ACCESS-state cycle limit (used only with BUS_TIMEOUT_EN)

Ports:
clk_in  input  1  system clock, 25 MHz
reset_in  input  1  synchronous, active-high reset
cpu_valid  input  1  picorv32 mem_valid
cpu_instr  input  1  picorv32 mem_instr
cpu_addr  input  32  byte address
cpu_wdata  input  32  write data
cpu_wstrb  input  4  byte enables; nonzero means write
cpu_ready  output  1  one-cycle completion pulse
cpu_rdata  output  32  registered read data
sel_out  output  3  one-hot slave enable: [0]=ROM, [1]=RAM, [2]=IO
write_out  output  1  registered |cpu_wstrb, valid while any sel_out bit is high
addr_out  output  30  word address, cpu_addr[31:2] minus the window base
wdata_out  output  32  registered cpu_wdata
wstrb_out  output  4  registered cpu_wstrb
slv_ready_in  input  3  per-slave ready, bit index matches sel_out
slv_rdata_in  input  96  per-slave read data; slave n occupies bits [32n+31:32n]
bus_error_out  output  1  sticky error flag
err_addr_out  output  32  cpu_addr of the first error since reset

Behaviour:
- Reset values: state IDLE; cpu_ready=0; cpu_rdata=0; sel_out=0; write_out=0; addr_out=0; wdata_out=0; wstrb_out=0; bus_error_out=0; err_addr_out=0; timeout counter=0.
- Reset asserted mid-transaction aborts it on the next edge. No cpu_ready is issued and sel_out drops.
- FSM states: IDLE, ACCESS, RESP, ERROR.
- IDLE: at an edge where cpu_valid=1, register addr_out, wdata_out, wstrb_out and write_out, then decode:
  - legal hit -> ACCESS, the matching sel_out bit set;
  - illegal -> ERROR, sel_out stays 0.
- Illegal accesses:
  - address outside all windows;
  - write to ROM;
  - instruction fetch from RAM or IO;
  - cpu_addr[1:0]!=0.
- ACCESS: hold sel_out and all registered outputs stable.
  - When slv_ready_in[selected]=1 at an edge: latch that slave's rdata into cpu_rdata, clear sel_out, go to RESP.
  - Ready bits of unselected slaves are ignored.
- RESP: cpu_ready=1 for exactly one cycle, then IDLE. cpu_rdata holds until the next response.
- ERROR: cpu_ready=1 for exactly one cycle with cpu_rdata=ERR_RDATA, then IDLE.
  - Set bus_error_out.
  - Load err_addr_out only if bus_error_out was 0 (first error wins).
  - Writes to ERR state complete with no slave side effect.
- Latency for a zero-wait slave (ready high during the first ACCESS cycle):
  - cpu_valid sampled at edge E0;
  - sel_out high E0-E1;
  - cpu_ready high E1-E2.
  - Each slave wait cycle adds one cycle.
- cpu_valid is not re-sampled in ACCESS, RESP or ERROR. Back-to-back requests are accepted in IDLE on the edge after RESP/ERROR ends.
- At most one sel_out bit is ever high. sel_out is never high in IDLE, RESP or ERROR.
- Window compare is base <= addr < base+size, unsigned 32-bit. Windows must not overlap; overlap is a configuration error and is not checked.

Optional Feature:
BUS_TIMEOUT_EN:
- Defined: a counter clears on entry to ACCESS and increments on each ACCESS cycle without the selected ready. When it reaches TIMEOUT_CYCLES, the next edge clears sel_out and enters ERROR, with the same error handling as a decode fault.
- Undefined: no counter; ACCESS waits indefinitely for the slave.

Test Plan:
- ROM fetch at 0x0000_0004, cpu_instr=1, zero-wait ROM returning 0x0000_0013 -> sel_out=3'b001 for 1 cycle; cpu_ready 2 cycles after valid sampled; cpu_rdata=0x0000_0013.
- RAM write 0x0000_1008, wstrb=4'b1111, wdata=0x1234_5678, RAM ready after 3 wait cycles -> sel_out=3'b010 held 4 cycles; addr_out=2, write_out=1; one cpu_ready pulse.
- Write to ROM 0x0000_0010, then a read from 0x2000_0000 -> both get a one-cycle cpu_ready with rdata=0xDEAD_BEEF; sel_out stays 0; bus_error_out=1; err_addr_out=0x0000_0010.
- IO read 0x1000_0004 with slv_ready_in=3'b011 (wrong slaves ready) for 5 cycles, then 3'b100 with rdata=0xA5 -> stays in ACCESS until bit 2; cpu_rdata=0x0000_00A5.
- reset_in pulsed during a stalled RAM ACCESS -> next edge: sel_out=0, cpu_ready=0, bus_error_out=0; a following RAM read completes normally.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=8, IO never ready -> sel_out drops after 8 ACCESS cycles; error response with 0xDEAD_BEEF; err_addr_out = IO address.
